// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: latches the PC word address, runs a req/ack read to
// instruction memory, loads the returned word into IR and pulses pc_inc once per fetch.
module instr_fetch_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              flush,
    input  logic [31:0]       pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ir_out,
    output logic              ir_valid,
    output logic              pc_inc,
    output logic              busy,
    output logic              fetch_err,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_latch_addr;
    logic               w_load_ir;

    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_ir;
    logic               r_ir_valid;
    logic               r_pc_inc;
    logic               r_busy;
    logic               r_fetch_err;

    // PC bits above the memory word address are deliberately not used.
    logic               w_unused_pc;
    assign w_unused_pc = ^pc_in[31:ADDR_W];

    // Next-state logic. Priority inside REQ: flush, then ack, then timeout.
    always_comb begin
        w_next_state = r_state;
        w_count_nxt  = r_count;
        w_latch_addr = 1'b0;
        w_load_ir    = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start && !flush) begin
                    w_next_state = ST_REQ;
                    w_latch_addr = 1'b1;
                    w_count_nxt  = '0;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (mem_ack) begin
                    w_next_state = ST_DONE;
                    w_load_ir    = 1'b1;
                end else if (r_count == CNT_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Every output is a flop decoded from the next state, so it is glitch-free
    // and lines up with the state it describes.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_count_nxt;
            r_mem_req   <= (w_next_state == ST_REQ);
            r_busy      <= (w_next_state == ST_REQ) || (w_next_state == ST_DONE);
            r_ir_valid  <= (w_next_state == ST_DONE);
            r_pc_inc    <= (w_next_state == ST_DONE);
            r_fetch_err <= (w_next_state == ST_ERR);
            if (w_latch_addr) begin
                r_mem_addr <= pc_in[ADDR_W-1:0];
            end
            if (w_load_ir) begin
                r_ir <= mem_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign ir_out    = r_ir;
    assign ir_valid  = r_ir_valid;
    assign pc_inc    = r_pc_inc;
    assign busy      = r_busy;
    assign fetch_err = r_fetch_err;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scenario tasks with random
// addresses, data and wait states, checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;

    // Output flag vectors {mem_req, busy, ir_valid, pc_inc, fetch_err}.
    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_REQ  = 5'b11000;
    localparam logic [4:0] F_DONE = 5'b01110;
    localparam logic [4:0] F_ERR  = 5'b00001;

    logic              clock;
    logic              clear_n;
    logic              start;
    logic              flush;
    logic [31:0]       pc_in;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [31:0]       ir_out;
    logic              ir_valid;
    logic              pc_inc;
    logic              busy;
    logic              fetch_err;
    logic [1:0]        state_dbg;

    int checks      = 0;
    int failures    = 0;
    int pulse_cnt   = 0;
    int exp_pulses  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_ir = 32'h0;

    wire [4:0] w_obs = {mem_req, busy, ir_valid, pc_inc, fetch_err};

    instr_fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .flush     (flush),
        .pc_in     (pc_in),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .pc_inc    (pc_inc),
        .busy      (busy),
        .fetch_err (fetch_err),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pc_inc === 1'b1) pulse_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One fetch: issue, `delay` wait edges, then ack (optionally with flush).
    task automatic do_fetch(input string tag, input logic [31:0] pc, input int delay,
                            input logic [31:0] rdata, input bit flush_on_ack,
                            input bit start_in_done);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = pc[ADDR_W-1:0];
        pc_in = pc; start = 1'b1; flush = 1'b0; mem_ack = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if (w_obs !== F_REQ || mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL %s_issue: obs=%b addr=%h, expected obs=%b addr=%h",
                     tag, w_obs, mem_addr, F_REQ, exp_addr);
        end
        for (int k = 0; k < delay; k++) begin
            pc_in = $urandom; mem_rdata = $urandom; mem_ack = 1'b0;
            step();
            checks++;
            if (w_obs !== F_REQ || mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL %s_wait%0d: obs=%b addr=%h, expected obs=%b addr=%h",
                         tag, k, w_obs, mem_addr, F_REQ, exp_addr);
            end
        end
        mem_ack = 1'b1; mem_rdata = rdata; flush = flush_on_ack;
        step();
        mem_ack = 1'b0; flush = 1'b0;
        if (flush_on_ack) begin
            checks++;
            if (w_obs !== F_IDLE || ir_out !== model_ir) begin
                failures++;
                $display("FAIL %s_flush: obs=%b ir=%h, expected obs=%b ir=%h",
                         tag, w_obs, ir_out, F_IDLE, model_ir);
            end
            mem_ack = 1'b1; mem_rdata = $urandom;
            step();
            mem_ack = 1'b0;
            checks++;
            if (w_obs !== F_IDLE || ir_out !== model_ir) begin
                failures++;
                $display("FAIL %s_late_ack: obs=%b ir=%h, expected obs=%b ir=%h",
                         tag, w_obs, ir_out, F_IDLE, model_ir);
            end
        end else begin
            exp_q.push_back(rdata);
            model_ir = exp_q[$];
            exp_pulses++;
            checks++;
            if (w_obs !== F_DONE || ir_out !== model_ir) begin
                failures++;
                $display("FAIL %s_done: obs=%b ir=%h, expected obs=%b ir=%h",
                         tag, w_obs, ir_out, F_DONE, model_ir);
            end
            start = start_in_done;
            flush = 1'($urandom_range(0, 1));
            step();
            start = 1'b0; flush = 1'b0;
            checks++;
            if (w_obs !== F_IDLE || ir_out !== model_ir) begin
                failures++;
                $display("FAIL %s_after_done: obs=%b ir=%h, expected obs=%b ir=%h",
                         tag, w_obs, ir_out, F_IDLE, model_ir);
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (w_obs !== F_IDLE || mem_addr !== '0 || ir_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_initial: obs=%b addr=%h ir=%h, expected all zero",
                     w_obs, mem_addr, ir_out);
        end
        clear_n = 1'b1;
        do_fetch("reset_pre", 32'h0000_0123, 1, 32'h1357_9BDF, 1'b0, 1'b0);
        pc_in = 32'h0000_00AA; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (w_obs !== F_REQ) begin
            failures++;
            $display("FAIL reset_enter_req: obs=%b, expected %b", w_obs, F_REQ);
        end
        #2 clear_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== F_IDLE || mem_addr !== '0 || ir_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: obs=%b addr=%h ir=%h, expected all zero",
                     w_obs, mem_addr, ir_out);
        end
        exp_q.delete();
        model_ir = 32'h0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        clear_n = 1'b1;
        step();
        checks++;
        if (w_obs !== F_IDLE || ir_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: obs=%b ir=%h, expected obs=%b ir=0",
                     w_obs, ir_out, F_IDLE);
        end
        do_fetch("reset_post", $urandom, $urandom_range(0, 4), $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        do_fetch("basic", 32'h0000_0005, 2, 32'hA5A5_1234, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt;
        do_fetch("b2b0", $urandom, 0, $urandom, 1'b0, 1'b1);
        do_fetch("b2b1", $urandom, 0, $urandom, 1'b0, 1'b0);
        do_fetch("b2b2", $urandom, 0, $urandom, 1'b0, 1'b1);
        checks++;
        if (pulse_cnt - p0 !== 3) begin
            failures++;
            $display("FAIL b2b_pulses: got=%0d expected=3", pulse_cnt - p0);
        end
    endtask

    task automatic test_flush();
        do_fetch("flush_ack", $urandom, $urandom_range(0, 15), 32'hDEAD_BEEF, 1'b1, 1'b0);
        start = 1'b1; flush = 1'b1; pc_in = $urandom;
        step();
        start = 1'b0; flush = 1'b0;
        checks++;
        if (w_obs !== F_IDLE) begin
            failures++;
            $display("FAIL flush_start_same_edge: obs=%b, expected %b", w_obs, F_IDLE);
        end
    endtask

    task automatic test_timeout();
        logic [ADDR_W-1:0] exp_addr;
        pc_in = $urandom; exp_addr = pc_in[ADDR_W-1:0]; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            pc_in = $urandom;
            step();
        end
        checks++;
        if (w_obs !== F_REQ) begin
            failures++;
            $display("FAIL timeout_edge15: obs=%b, expected %b", w_obs, F_REQ);
        end
        step();
        checks++;
        if (w_obs !== F_ERR || mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL timeout_err: obs=%b addr=%h, expected obs=%b addr=%h",
                     w_obs, mem_addr, F_ERR, exp_addr);
        end
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            step();
            mem_ack = 1'b0; flush = 1'b0;
            checks++;
            if (w_obs !== F_ERR || ir_out !== model_ir) begin
                failures++;
                $display("FAIL timeout_hold%0d: obs=%b ir=%h, expected obs=%b ir=%h",
                         k, w_obs, ir_out, F_ERR, model_ir);
            end
        end
        do_fetch("err_restart", $urandom, $urandom_range(0, 3), $urandom, 1'b0, 1'b0);
        do_fetch("ack_at_limit", $urandom, TIMEOUT - 1, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_addr_wrap();
        do_fetch("wrap", 32'h0000_0205, 3, $urandom, 1'b0, 1'b0);
        do_fetch("wrap_hi", 32'hFFFF_FE00 | 32'($urandom_range(0, 511)), 1, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_fetch($sformatf("rand%0d", i), $urandom, $urandom_range(0, TIMEOUT - 1),
                     $urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        clear_n = 1'b0; start = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        pc_in = 32'h0; mem_rdata = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_addr_wrap();
        test_random();
        step();
        checks++;
        if (pulse_cnt !== exp_pulses) begin
            failures++;
            $display("FAIL pc_inc_total: got=%0d expected=%0d", pulse_cnt, exp_pulses);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
